dp_ram_ctrl: RTL
================

Name: dp_ram_ctrl

Overview:
- Parametrised true dual-port RAM. Successor to the single-port RAM.
- Two independent read/write ports (A, B) share one clock and one memory array.
- Adds per-byte write enables, selectable read latency (1 or 2), selectable read-during-write mode, defined write-collision priority, and a post-reset hardware clear sequencer.
- Sits behind bus adapters as the shared scratch buffer. Verified with the same clocking-block style bench as the single-port RAM.

Parameters:
- DEPTH, 16, number of words. Any value ≥2; need not be a power of 2.
- WIDTH, 32, word width in bits. Must be a multiple of 8.
- READ_LAT, 1, read latency in cycles. Legal values are 1 or 2; 2 adds an output register stage.
- RDW_MODE, 0, read-during-write mode. 0 = read-first (returns old data); 1 = write-first (returns new merged data).
- INIT_VALUE, 0, word written to every location by the clear sequencer.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- init_busy  out  1  high while reset is asserted and while the clear sequencer runs.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_be  in  WIDTH/8  port A byte enables. Used for writes only.
- a_addr  in  $clog2(DEPTH)  port A address.
- a_wdata  in  WIDTH  port A write data.
- a_rdata  out  WIDTH  port A read data.
- a_rvalid  out  1  port A read data valid.
- b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: identical to port A, for port B.

Behaviour:
- Reset (async assert):
  - a_rdata/b_rdata = 0, a_rvalid/b_rvalid = 0, all pipeline registers = 0.
  - init_busy = 1; clear counter = 0.
  - Array contents are not reset directly.
- Clear FSM, states IDLE, CLEAR:
  - Reset places the FSM in CLEAR.
  - In CLEAR, each cycle writes INIT_VALUE to address cnt, then cnt++.
  - When cnt == DEPTH-1 has been written, move to IDLE and drop init_busy on the next edge.
  - init_busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - Reset asserted mid-clear restarts the clear from address 0.
- While init_busy = 1:
  - a_en and b_en are ignored: no array writes, no rvalid.
- Accepted access: en = 1 at a posedge with init_busy = 0.
- Write: for each byte i with be[i] = 1, mem[addr][8i+7:8i] <= wdata byte i. Bytes with be[i] = 0 are unchanged. be = 0 is a legal no-op write.
- Every accepted access (read or write) produces rvalid = 1 for one cycle, READ_LAT cycles after the accepting edge. rdata is valid in that same cycle.
- Back-to-back accesses are fully pipelined: throughput is 1 access per port per cycle.
- rdata holds its last value when rvalid = 0.
- Write access rdata:
  - RDW_MODE = 0: pre-write word.
  - RDW_MODE = 1: post-write merged word.
- Cross-port, same address, same cycle, one port writing and the other reading: the reader's result follows RDW_MODE, old or merged new word.
- Both ports write the same address in the same cycle:
  - Byte-wise merge; port A wins on bytes enabled by both.
  - Bytes enabled only by B take B's data.
  - Each port's rdata follows RDW_MODE against the final stored word (mode 1) or the pre-write word (mode 0).
- Address ≥ DEPTH (non-power-of-2 DEPTH):
  - Writes are dropped.
  - Reads return 0 with rvalid still asserted.
- Port A and port B paths are otherwise fully independent. There is no back-pressure.

Decomposition:
- Package dp_ram_pkg holds:
  - rdw_mode_e enum (RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1).
  - clear FSM state enum (ST_IDLE, ST_CLEAR).
  - localparam helpers: BE_W = WIDTH/8, AW = $clog2(DEPTH).
- One natural sub-module: dp_ram_rd_pipe.
  - Per-port rvalid/rdata delay line of depth READ_LAT.
  - Instantiated twice.
- Merge, collision logic and the clear FSM stay in the top module.

Test Plan:
- Reset/clear: DEPTH=16, INIT_VALUE=32'hDEAD_BEEF; pulse rst, then wait 16 cycles -> init_busy high for exactly 16 cycles after deassert; a read at any address then returns 32'hDEAD_BEEF with rvalid READ_LAT cycles later.
- Byte enables: write A addr 3 = 32'h1122_3344 with be=4'hF, then be=4'b0101 with wdata 32'hAABB_CCDD; read B addr 3 -> 32'h11BB_33DD.
- Read-during-write: RDW_MODE=0 vs 1; mem[5]=32'h0; same cycle A writes 32'h55 to addr 5 while B reads addr 5 -> B returns 32'h0 (mode 0) or 32'h55 (mode 1).
- Write collision: A writes addr 7 = 32'hAAAA_AAAA with be=4'b0011; B writes addr 7 = 32'hBBBB_BBBB with be=4'b0110 -> mem[7] = 32'h00BB_AAAA after clear-to-0.
- Latency/throughput: READ_LAT=2; issue 4 consecutive reads on A, addrs 0-3 -> rvalid high on cycles 2-5 after the first request, data in order; then assert rst mid-stream -> rvalid drops immediately and clear restarts at addr 0.
- Busy gating and range: issue writes during init_busy -> no effect, no rvalid. DEPTH=12, read addr 13 -> rdata 0 with rvalid=1; write to addr 13 leaves addrs 0-11 unchanged.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and sizing helpers for the dual-port scratch RAM.
package dp_ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_e;

  function automatic int be_width(input int width);
    return width / 8;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Per-port read-response delay line; rdata holds its last value between responses.
module dp_ram_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata
);

  logic [LAT-1:0]   v;
  logic [WIDTH-1:0] d [LAT];

  // Each stage only loads on a valid beat so the output word holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) begin
        d[i] <= '0;
      end
    end else begin
      v[0] <= valid;
      if (valid) begin
        d[0] <= data;
      end
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign rvalid = v[LAT-1];
  assign rdata  = d[LAT-1];

endmodule

// File: rtl/dp_ram_ctrl.sv
// True dual-port RAM with byte enables, selectable read latency / RDW mode,
// A-over-B write collision priority and a post-reset clear sequencer.
module dp_ram_ctrl
  import dp_ram_pkg::*;
#(
  parameter int               DEPTH      = 16,
  parameter int               WIDTH      = 32,
  parameter int               READ_LAT   = 1,
  parameter int               RDW_MODE   = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              init_busy,
  input  logic                              a_en,
  input  logic                              a_we,
  input  logic [be_width(WIDTH)-1:0]        a_be,
  input  logic [addr_width(DEPTH)-1:0]      a_addr,
  input  logic [WIDTH-1:0]                  a_wdata,
  output logic [WIDTH-1:0]                  a_rdata,
  output logic                              a_rvalid,
  input  logic                              b_en,
  input  logic                              b_we,
  input  logic [be_width(WIDTH)-1:0]        b_be,
  input  logic [addr_width(DEPTH)-1:0]      b_addr,
  input  logic [WIDTH-1:0]                  b_wdata,
  output logic [WIDTH-1:0]                  b_rdata,
  output logic                              b_rvalid
);

  localparam int             BE_W  = be_width(WIDTH);
  localparam int             AW    = addr_width(DEPTH);
  localparam logic [AW-1:0]  LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]    LIMIT = (AW + 1)'(DEPTH);
  localparam rdw_mode_e      RDW   = (RDW_MODE == 1) ? RDW_WRITE_FIRST : RDW_READ_FIRST;

  logic [WIDTH-1:0] mem [DEPTH];
  clear_state_e     state;
  logic [AW-1:0]    cnt;
  logic             busy;

  logic             a_acc, b_acc, a_ok, b_ok, a_wr, b_wr;
  logic [WIDTH-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;

  assign init_busy = busy;

  assign a_acc = a_en & ~busy;
  assign b_acc = b_en & ~busy;
  assign a_ok  = {1'b0, a_addr} < LIMIT;
  assign b_ok  = {1'b0, b_addr} < LIMIT;
  assign a_wr  = a_acc & a_we & a_ok;
  assign b_wr  = b_acc & b_we & b_ok;

  assign a_old = a_ok ? mem[a_addr] : '0;
  assign b_old = b_ok ? mem[b_addr] : '0;

  // Both ports compute the final stored word at their own address: B's bytes first, A's on top
  always_comb begin
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < BE_W; i++) begin
      if (b_wr && b_be[i] && (b_addr == a_addr)) a_new[8*i +: 8] = b_wdata[8*i +: 8];
      if (a_wr && a_be[i])                       a_new[8*i +: 8] = a_wdata[8*i +: 8];
      if (b_wr && b_be[i])                       b_new[8*i +: 8] = b_wdata[8*i +: 8];
      if (a_wr && a_be[i] && (a_addr == b_addr)) b_new[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  assign a_rd = (RDW == RDW_WRITE_FIRST) ? a_new : a_old;
  assign b_rd = (RDW == RDW_WRITE_FIRST) ? b_new : b_old;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // When both ports hit the same address they store the identical merged word
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= INIT_VALUE;
    end else begin
      if (a_wr) mem[a_addr] <= a_new;
      if (b_wr) mem[b_addr] <= b_new;
    end
  end

  dp_ram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LAT)) u_pipe_a (
    .clk    (clk),
    .rst    (rst),
    .valid  (a_acc),
    .data   (a_rd),
    .rvalid (a_rvalid),
    .rdata  (a_rdata)
  );

  dp_ram_rd_pipe #(.WIDTH(WIDTH), .LAT(READ_LAT)) u_pipe_b (
    .clk    (clk),
    .rst    (rst),
    .valid  (b_acc),
    .data   (b_rd),
    .rvalid (b_rvalid),
    .rdata  (b_rdata)
  );

endmodule
